pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_if.sv | 33 +++
 rtl/pipe_hazard_ctrl_sat_cnt16.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  localparam int REG_IDX_W          = 3;
  localparam int WORD_W             = 16;
  localparam logic [WORD_W-1:0] NOP = 16'h0000;
  localparam int BR_PENALTY_DEFAULT = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-detection inputs from ID/EX/MEM and pipeline load/flush commands back to them.
interface pipe_hazard_ctrl_if;
  import pipe_pkg::*;

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_is_load;
  logic                 ex_valid;
  logic                 br_taken;
  logic                 mem_busy;
  logic                 pc_load;
  logic                 ifid_load;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic [WORD_W-1:0]    stall_cnt;
  logic [WORD_W-1:0]    flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_valid,
           br_taken, mem_busy,
    input  pc_load, ifid_load, ifid_flush, idex_flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_valid,
           br_taken, mem_busy,
    output pc_load, ifid_load, ifid_flush, idex_flush, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_cnt16.sv
// 16-bit performance counter with enable and clear that saturates at all-ones.
module sat_cnt16
  import pipe_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              en,
  input  logic              clr,
  output logic [WORD_W-1:0] cnt
);

  logic [WORD_W-1:0] cnt_reg;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)      cnt_reg <= '0;
    else if (clr)   cnt_reg <= '0;
    else if (en)    cnt_reg <= sat_inc(cnt_reg);
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and memory-wait holds,
// with saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int BR_PENALTY = BR_PENALTY_DEFAULT
) (
  input  logic             CLK,
  input  logic             RSTN,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [2:0] FCNT_INIT = 3'(BR_PENALTY - 1);

  state_t     state_reg, state_next;
  state_t     ret_state_reg, ret_state_next;
  state_t     eff_state;
  logic [2:0] fcnt_reg, fcnt_next;
  logic       lu;

  logic pc_ld, ifid_ld, ifid_fl, idex_fl;
  logic [1:0]        cnt_en;
  logic [WORD_W-1:0] cnt_val [2];

  assign lu = hz.ex_valid && hz.ex_is_load && (hz.ex_rd != '0) &&
              ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
               (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // Leaving MEM_WAIT behaves exactly like the state that was interrupted.
  assign eff_state = (state_reg == MEM_WAIT) ? ret_state_reg : state_reg;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg     <= RUN;
      ret_state_reg <= RUN;
      fcnt_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      ret_state_reg <= ret_state_next;
      fcnt_reg      <= fcnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ret_state_next = ret_state_reg;
    fcnt_next      = fcnt_reg;
    if (hz.mem_busy) begin
      state_next = MEM_WAIT;
      if (state_reg != MEM_WAIT) ret_state_next = state_reg;
    end else if (hz.br_taken) begin
      state_next = (BR_PENALTY > 1) ? FLUSH : RUN;
      fcnt_next  = FCNT_INIT;
    end else if (eff_state == FLUSH) begin
      // fcnt counts the FLUSH cycles still to issue, including this one.
      fcnt_next  = (fcnt_reg != 3'd0) ? fcnt_reg - 3'd1 : 3'd0;
      state_next = (fcnt_reg <= 3'd1) ? RUN : FLUSH;
    end else begin
      state_next = RUN;
    end
  end

  always_comb begin
    pc_ld   = 1'b1;
    ifid_ld = 1'b1;
    ifid_fl = 1'b0;
    idex_fl = 1'b0;
    if (RSTN) begin
      if (hz.mem_busy) begin
        pc_ld   = 1'b0;
        ifid_ld = 1'b0;
      end else if (hz.br_taken) begin
        ifid_fl = 1'b1;
        idex_fl = 1'b1;
      end else if (eff_state == FLUSH) begin
        ifid_fl = 1'b1;
      end else if (lu) begin
        pc_ld   = 1'b0;
        ifid_ld = 1'b0;
        idex_fl = 1'b1;
      end
    end
  end

  assign cnt_en[0] = hz.mem_busy || (eff_state == RUN && !hz.br_taken && lu);
  assign cnt_en[1] = !hz.mem_busy && (hz.br_taken || eff_state == FLUSH);

  // Index 0 counts stall cycles, index 1 counts flush cycles.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_cnt16 u_cnt (
        .CLK  (CLK),
        .RSTN (RSTN),
        .en   (cnt_en[gi]),
        .clr  (1'b0),
        .cnt  (cnt_val[gi])
      );
    end
  endgenerate

  assign hz.pc_load    = pc_ld;
  assign hz.ifid_load  = ifid_ld;
  assign hz.ifid_flush = ifid_fl;
  assign hz.idex_flush = idex_fl;
  assign hz.stall_cnt  = cnt_val[0];
  assign hz.flush_cnt  = cnt_val[1];

endmodule
